// File: rtl/ip_pkg.sv
// ip_pkg: shared types and constants for the IPv4 transmit framer.
//   state_t      framer FSM states
//   L4_*         l4_mode encodings (reserved is handled as none)
//   IP_VERSION   version nibble placed in header word 0
//   MIN_IHL      header length in 32-bit words without options
package ip_pkg;
    typedef enum logic [2:0] {S_IDLE, S_CALC, S_HDR, S_DATA, S_DONE} state_t;
    localparam logic [1:0] L4_NONE = 2'd0;
    localparam logic [1:0] L4_UDP  = 2'd1;
    localparam logic [1:0] L4_TCP  = 2'd2;
    localparam logic [1:0] L4_RSVD = 2'd3;
    localparam logic [3:0] IP_VERSION = 4'd4;
    localparam logic [3:0] MIN_IHL    = 4'd5;
endpackage

// File: rtl/ip_csum_acc.sv
// ip_csum_acc: 16-bit one's-complement (end-around-carry) accumulator.
//   clk, reset  clock, async active-low reset
//   clear       zero the running sum
//   en          fold add32 into the sum this cycle
//   add32       32-bit word, added as two 16-bit halves
//   sum16       registered running sum
module ip_csum_acc (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        en,
    input  logic [31:0] add32,
    output logic [15:0] sum16
);
    logic [15:0] r_sum;
    logic [17:0] w_t;
    logic [16:0] w_u;

    // two halves plus the sum can carry twice; fold both carries back in
    assign w_t   = {2'b0, r_sum} + {2'b0, add32[31:16]} + {2'b0, add32[15:0]};
    assign w_u   = {1'b0, w_t[15:0]} + {15'b0, w_t[17:16]};
    assign sum16 = r_sum;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_sum <= 16'h0;
        else if (clear)
            r_sum <= 16'h0;
        else if (en)
            r_sum <= w_u[15:0] + {15'b0, w_u[16]};
    end
endmodule

// File: rtl/ip_tx_framer.sv
// ip_tx_framer: builds an IPv4 header (with options and checksum) and frames the payload.
//   clk, reset                    clock, async active-low reset
//   start                         latch all header inputs (IDLE only)
//   tos..opt_data, len_in         header fields, options, payload byte count
//   l4_mode, l4_checksum          optional UDP/TCP checksum patch into the payload
//   in_data/in_valid/in_ready     payload stream in
//   out_data/out_valid/out_ready  framed stream out, out_last on final word
//   len_out, hdr_checksum         total_length and computed header checksum
//   busy, fin                     not-IDLE flag, one-cycle completion pulse
module ip_tx_framer
    import ip_pkg::*;
#(
    parameter int         OPT_MAX     = 10,
    parameter logic [7:0] TTL_DEFAULT = 8'd64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            tos,
    input  logic [7:0]            ttl_in,
    input  logic [7:0]            protocol,
    input  logic [15:0]           identification,
    input  logic [2:0]            flag,
    input  logic [12:0]           frag_offset,
    input  logic [31:0]           src_ip,
    input  logic [31:0]           dest_ip,
    input  logic [3:0]            opt_words,
    input  logic [32*OPT_MAX-1:0] opt_data,
    input  logic [15:0]           len_in,
    input  logic [1:0]            l4_mode,
    input  logic [15:0]           l4_checksum,
    input  logic [31:0]           in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [31:0]           out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic [15:0]           len_out,
    output logic [15:0]           hdr_checksum,
    output logic                  busy,
    output logic                  fin
);
    localparam logic [3:0] OPT_MAX4 = 4'(OPT_MAX);

    state_t                r_state, w_next;
    logic [7:0]            r_tos, r_ttl, r_proto;
    logic [15:0]           r_id, r_len, r_l4, r_hdr_csum;
    logic [2:0]            r_flag;
    logic [12:0]           r_frag;
    logic [31:0]           r_src, r_dst, r_out_data;
    logic [32*OPT_MAX-1:0] r_opt;
    logic [3:0]            r_k, r_idx, w_k, w_hlast, w_oi;
    logic [14:0]           r_nwords, r_pidx;
    logic [1:0]            r_mode;
    logic                  r_all, r_out_valid, r_out_last;
    logic                  w_free, w_hs, w_load, w_last;
    logic [15:0]           w_sum, w_csum_fld;
    logic [31:0]           w_hdr, w_pay, w_word;

    assign w_k        = (opt_words > OPT_MAX4) ? OPT_MAX4 : opt_words;
    assign w_hlast    = MIN_IHL - 4'd1 + r_k;
    assign w_oi       = r_idx - MIN_IHL;
    // the checksum field is summed as zero and only filled in once emitting
    assign w_csum_fld = (r_state == S_HDR) ? ~w_sum : 16'h0;
    assign w_hdr = (r_idx == 4'd0) ? {IP_VERSION, MIN_IHL + r_k, r_tos, r_len}
                 : (r_idx == 4'd1) ? {r_id, r_flag, r_frag}
                 : (r_idx == 4'd2) ? {r_ttl, r_proto, w_csum_fld}
                 : (r_idx == 4'd3) ? r_src
                 : (r_idx == 4'd4) ? r_dst
                 : r_opt[{w_oi, 5'd0} +: 32];
    assign w_pay = (r_mode == L4_UDP && r_pidx == 15'd1) ? {in_data[31:16], r_l4}
                 : (r_mode == L4_TCP && r_pidx == 15'd4) ? {r_l4, in_data[15:0]}
                 : in_data;
    assign w_free   = !r_out_valid || out_ready;
    assign w_hs     = r_out_valid && out_ready;
    // r_all blocks further loads (and payload acceptance) once the last word is queued
    assign in_ready = (r_state == S_DATA) && w_free && !r_all;
    assign w_load   = w_free && !r_all && (r_state == S_HDR || (r_state == S_DATA && in_valid));
    assign w_word   = (r_state == S_DATA) ? w_pay : w_hdr;
    assign w_last   = (r_state == S_DATA) ? (r_pidx == r_nwords - 15'd1)
                                          : (r_idx == w_hlast && r_nwords == 15'd0);

    assign out_data     = r_out_data;
    assign out_valid    = r_out_valid;
    assign out_last     = r_out_last;
    assign len_out      = r_len;
    assign hdr_checksum = r_hdr_csum;
    assign busy         = r_state != S_IDLE;
    assign fin          = r_state == S_DONE;

    ip_csum_acc u_acc (
        .clk   (clk),
        .reset (reset),
        .clear (r_state == S_IDLE && start),
        .en    (r_state == S_CALC),
        .add32 (w_hdr),
        .sum16 (w_sum)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (start) w_next = S_CALC;
            S_CALC: if (r_idx == w_hlast) w_next = S_HDR;
            S_HDR:  if (r_all && w_hs) w_next = S_DONE;
                    else if (w_load && r_idx == w_hlast && r_nwords != 15'd0) w_next = S_DATA;
            S_DATA: if (r_all && w_hs) w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tos <= '0; r_ttl <= '0; r_proto <= '0; r_id <= '0; r_flag <= '0; r_frag <= '0;
            r_src <= '0; r_dst <= '0; r_opt <= '0; r_k <= '0; r_len <= '0; r_nwords <= '0;
            r_mode <= L4_NONE; r_l4 <= '0; r_idx <= '0; r_pidx <= '0; r_all <= 1'b0;
            r_hdr_csum <= '0; r_out_data <= '0; r_out_valid <= 1'b0; r_out_last <= 1'b0;
        end else begin
            if (r_state == S_IDLE && start) begin
                r_tos    <= tos;
                r_ttl    <= (ttl_in == 8'd0) ? TTL_DEFAULT : ttl_in;
                r_proto  <= protocol;
                r_id     <= identification;
                r_flag   <= flag;
                r_frag   <= frag_offset;
                r_src    <= src_ip;
                r_dst    <= dest_ip;
                r_opt    <= opt_data;
                r_k      <= w_k;
                r_len    <= 16'd20 + {10'd0, w_k, 2'b00} + len_in;
                r_nwords <= 15'((17'(len_in) + 17'd3) >> 2);
                r_mode   <= (l4_mode == L4_RSVD) ? L4_NONE : l4_mode;
                r_l4     <= l4_checksum;
                r_idx    <= 4'd0;
                r_pidx   <= 15'd0;
                r_all    <= 1'b0;
            end
            if (r_state == S_CALC)
                r_idx <= (r_idx == w_hlast) ? 4'd0 : r_idx + 4'd1;
            if (r_state == S_HDR)
                r_hdr_csum <= ~w_sum;
            if (w_load) begin
                r_out_data  <= w_word;
                r_out_valid <= 1'b1;
                r_out_last  <= w_last;
                r_all       <= w_last;
                if (r_state == S_HDR)
                    r_idx <= r_idx + 4'd1;
                else
                    r_pidx <= r_pidx + 15'd1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end
    end
endmodule
